ddr3_rw_arbiter: RTL and testbench
==================================

// Module: ddr3_rw_arbiter
// PURPOSE
//  Shares the single DDR3 controller command port between the AXI read-path command FIFO and the write-path command FIFO.
//  Grants one path at a time, never splits a sequential (rseq/wseq) chunk chain, and batches same-direction commands to cut bus turnarounds.
//  Sits between the rd/wr path command outputs and the DDR3 FSM command input.
// PARAMETERS
//  ADDRS         32  command address width
//  AXI_ID_WIDTH  4   request-ID width
//  MAX_RUN       8   max commands granted to one side while the other waits (>=1)
// PORTS
//  clock        in   1        system clock
//  reset        in   1        synchronous, active-high reset
//  rd_fetch_i   in   1        read command valid
//  rd_accept_o  out  1        read command taken (valid & accept = transfer)
//  rd_rseq_i    in   1        1 = next read command continues this sequence
//  rd_reqid_i   in   ID       read request ID
//  rd_addr_i    in   ADDRS    read address
//  wr_store_i   in   1        write command valid
//  wr_accept_o  out  1        write command taken
//  wr_wseq_i    in   1        1 = next write command continues this sequence
//  wr_reqid_i   in   ID       write request ID
//  wr_addr_i    in   ADDRS    write address
//  mem_req_o    out  1        command valid to DDR3 FSM
//  mem_accept_i in   1        DDR3 FSM takes command this cycle
//  mem_rdwr_o   out  1        1 = read, 0 = write
//  mem_seq_o    out  1        sequence flag of the presented command
//  mem_reqid_o  out  ID       request ID of the presented command
//  mem_addr_o   out  ADDRS    address of the presented command
// BEHAVIOUR
//  - States: ST_IDLE, ST_READ, ST_WRITE (registered grant); 4-bit run counter; 1-bit last-served flag; 1-bit lock flag.
//  - Reset: state=ST_IDLE, run=0, lock=0, last-served=write (reads win first tie); mem_req_o=0, rd/wr_accept_o=0, mem_rdwr_o=1, mem_seq_o=0, mem_reqid_o=0, mem_addr_o=0.
//  - mem_* outputs are combinational muxes of the granted side; mem_req_o = granted side's valid; ST_IDLE drives mem_req_o=0.
//  - rd_accept_o = (state==ST_READ) & mem_accept_i & rd_fetch_i; likewise wr_accept_o for ST_WRITE; never both high.
//  - Latency: request in ST_IDLE -> grant registered next edge -> mem_req_o high 1 cycle after request.
//  - ST_IDLE: only one valid -> grant it; both -> grant the side opposite last-served; none -> stay.
//  - A transfer with seq=1 sets lock; lock holds the grant unconditionally, even if the side drops valid (mem_req_o=0 while waiting).
//  - A transfer with seq=0 is a boundary: clear lock, run=run+1 (saturates at MAX_RUN), then decide:
//    - other side valid and switch condition -> grant other, run=0, last-served=current;
//    - else current valid -> keep grant;
//    - else -> ST_IDLE, run=0.
//  - Run counts completed sequences (boundaries), not chunks; a chain of any length counts as 1.
//  - Simultaneous boundary transfer and new request on other side: decision uses the same-cycle valids.
//  - Granted side drops valid while unlocked and other is valid -> switch on next edge without a transfer; neither valid -> ST_IDLE.
//  - mem_accept_i while mem_req_o=0 is ignored; commands are never dropped or duplicated.
//  - Reset asserted mid-chain: abandon lock immediately, return to reset values next edge.
// CONFIGURATION
//  ARB_BATCH_EN defined: switch condition = (run+1 >= MAX_RUN); same-direction sequences batch up to MAX_RUN while the other side waits.
//  ARB_BATCH_EN undefined: switch condition = 1; strict alternation at every boundary when both sides are pending; MAX_RUN unused.
// TESTING
//  1 Reads only: rd_fetch_i=1, rseq=0, addr 0x100,0x140,0x180 -> 3 transfers, mem_rdwr_o=1, first mem_req_o 1 cycle after fetch.
//  2 Chain lock: read chain rseq=1,1,0 while wr_store_i=1 -> all 3 reads issue back-to-back before any write; wr_accept_o=0 throughout.
//  3 Tie after reset: rd_fetch_i and wr_store_i high in cycle 0 -> first grant is read; next boundary grants write (no batch) or after 8 reads (ARB_BATCH_EN, MAX_RUN=8).
//  4 Stall in chain: read rseq=1 accepted, then rd_fetch_i low 5 cycles with wr_store_i=1 -> grant stays ST_READ, mem_req_o=0, no write issued.
//  5 Backpressure: mem_accept_i=0 for 10 cycles with both pending -> mem_* stable, no accept strobes, grant unchanged.
//  6 Reset mid-chain: assert reset after rseq=1 transfer -> next cycle ST_IDLE, all outputs at reset values; fresh write served first if only requester.

Source files
------------

// File: rtl/ddr3_rw_arbiter_if.sv
// Command-port bundle between the rd/wr path command FIFOs, the read/write arbiter and the DDR3 FSM.
// master = command producers/consumer side, slave = arbiter.
interface ddr3_rw_arbiter_if #(
   parameter int ADDRS        = 32,
   parameter int AXI_ID_WIDTH = 4
) ();
   logic                    rd_fetch_i;
   logic                    rd_accept_o;
   logic                    rd_rseq_i;
   logic [AXI_ID_WIDTH-1:0] rd_reqid_i;
   logic [ADDRS-1:0]        rd_addr_i;
   logic                    wr_store_i;
   logic                    wr_accept_o;
   logic                    wr_wseq_i;
   logic [AXI_ID_WIDTH-1:0] wr_reqid_i;
   logic [ADDRS-1:0]        wr_addr_i;
   logic                    mem_req_o;
   logic                    mem_accept_i;
   logic                    mem_rdwr_o;
   logic                    mem_seq_o;
   logic [AXI_ID_WIDTH-1:0] mem_reqid_o;
   logic [ADDRS-1:0]        mem_addr_o;

   modport master (
      output rd_fetch_i, rd_rseq_i, rd_reqid_i, rd_addr_i,
      output wr_store_i, wr_wseq_i, wr_reqid_i, wr_addr_i,
      output mem_accept_i,
      input  rd_accept_o, wr_accept_o,
      input  mem_req_o, mem_rdwr_o, mem_seq_o, mem_reqid_o, mem_addr_o
   );

   modport slave (
      input  rd_fetch_i, rd_rseq_i, rd_reqid_i, rd_addr_i,
      input  wr_store_i, wr_wseq_i, wr_reqid_i, wr_addr_i,
      input  mem_accept_i,
      output rd_accept_o, wr_accept_o,
      output mem_req_o, mem_rdwr_o, mem_seq_o, mem_reqid_o, mem_addr_o
   );
endinterface

// File: rtl/ddr3_rw_arbiter.sv
// Read/write command arbiter in front of the DDR3 FSM: chain-locked grants, batching when ARB_BATCH_EN
// is defined (up to MAX_RUN sequences per side), strict alternation at every boundary otherwise.
module ddr3_rw_arbiter #(
   parameter int ADDRS        = 32,
   parameter int AXI_ID_WIDTH = 4,
   parameter int MAX_RUN      = 8
) (
   input  logic               clock,
   input  logic               reset,
   ddr3_rw_arbiter_if.slave   bus
);
   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_READ  = 2'b01,
      ST_WRITE = 2'b10
   } state_t;

   localparam logic [3:0] MAX_RUN_C = 4'(MAX_RUN);

   state_t                  state_r, state_s, other_s;
   logic [3:0]              run_r, run_s, run_inc_s;
   logic                    last_rd_r, last_rd_s;
   logic                    lock_r, lock_s;
   logic                    cur_valid_s, oth_valid_s, cur_seq_s, xfer_s, switch_ok_s;
   logic [AXI_ID_WIDTH-1:0] reqid_s;
   logic [ADDRS-1:0]        addr_s;

   // Select the granted side's command; idle presents nothing.
   always_comb begin
      cur_valid_s = 1'b0;
      oth_valid_s = 1'b0;
      cur_seq_s   = 1'b0;
      reqid_s     = {AXI_ID_WIDTH{1'b0}};
      addr_s      = {ADDRS{1'b0}};
      other_s     = ST_READ;
      case (state_r)
         ST_READ: begin
            cur_valid_s = bus.rd_fetch_i;
            oth_valid_s = bus.wr_store_i;
            cur_seq_s   = bus.rd_rseq_i;
            reqid_s     = bus.rd_reqid_i;
            addr_s      = bus.rd_addr_i;
            other_s     = ST_WRITE;
         end
         ST_WRITE: begin
            cur_valid_s = bus.wr_store_i;
            oth_valid_s = bus.rd_fetch_i;
            cur_seq_s   = bus.wr_wseq_i;
            reqid_s     = bus.wr_reqid_i;
            addr_s      = bus.wr_addr_i;
            other_s     = ST_READ;
         end
         default: begin
            cur_valid_s = 1'b0;
            other_s     = ST_READ;
         end
      endcase
   end

   assign xfer_s          = cur_valid_s & bus.mem_accept_i;
   assign run_inc_s       = (run_r >= MAX_RUN_C) ? MAX_RUN_C : run_r + 4'd1;
`ifdef ARB_BATCH_EN
   // Compare with the pre-increment count so a side gets exactly MAX_RUN sequences.
   assign switch_ok_s     = ({1'b0, run_r} + 5'd1) >= {1'b0, MAX_RUN_C};
`else
   assign switch_ok_s     = 1'b1;
`endif

   assign bus.mem_req_o   = cur_valid_s;
   assign bus.mem_rdwr_o  = (state_r != ST_WRITE);
   assign bus.mem_seq_o   = cur_seq_s;
   assign bus.mem_reqid_o = reqid_s;
   assign bus.mem_addr_o  = addr_s;
   assign bus.rd_accept_o = (state_r == ST_READ)  & bus.mem_accept_i & bus.rd_fetch_i;
   assign bus.wr_accept_o = (state_r == ST_WRITE) & bus.mem_accept_i & bus.wr_store_i;

   // Grant decision: lock holds the grant, boundaries may hand it over.
   always_comb begin
      state_s   = state_r;
      run_s     = run_r;
      last_rd_s = last_rd_r;
      lock_s    = lock_r;
      case (state_r)
         ST_IDLE: begin
            if (bus.rd_fetch_i && bus.wr_store_i) begin
               state_s = last_rd_r ? ST_WRITE : ST_READ;
            end else if (bus.rd_fetch_i) begin
               state_s = ST_READ;
            end else if (bus.wr_store_i) begin
               state_s = ST_WRITE;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_READ, ST_WRITE: begin
            if (xfer_s && cur_seq_s) begin
               lock_s = 1'b1;
            end else if (xfer_s) begin
               lock_s = 1'b0;
               run_s  = run_inc_s;
               if (oth_valid_s && switch_ok_s) begin
                  state_s   = other_s;
                  run_s     = 4'd0;
                  last_rd_s = (state_r == ST_READ);
               end else begin
                  state_s = state_r;
               end
            end else if (lock_r) begin
               state_s = state_r;
            end else if (!cur_valid_s && oth_valid_s) begin
               state_s   = other_s;
               run_s     = 4'd0;
               last_rd_s = (state_r == ST_READ);
            end else if (!cur_valid_s) begin
               state_s = ST_IDLE;
               run_s   = 4'd0;
            end else begin
               state_s = state_r;
            end
         end
         default: begin
            state_s = ST_IDLE;
            run_s   = 4'd0;
            lock_s  = 1'b0;
         end
      endcase
   end

   // State registers; reset leaves write as last-served so reads win the first tie.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r   <= ST_IDLE;
         run_r     <= 4'd0;
         last_rd_r <= 1'b0;
         lock_r    <= 1'b0;
      end else begin
         state_r   <= state_s;
         run_r     <= run_s;
         last_rd_r <= last_rd_s;
         lock_r    <= lock_s;
      end
   end
endmodule

// File: tb/tb_ddr3_rw_arbiter.sv
// Self-checking bench for ddr3_rw_arbiter: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a grant/turn model and per-side command scoreboards.
module tb_ddr3_rw_arbiter;
   localparam int ADDRS   = 32;
   localparam int IDW     = 4;
   localparam int MAX_RUN = 8;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  id;
      logic        seq;
   } cmd_t;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   ddr3_rw_arbiter_if #(.ADDRS(ADDRS), .AXI_ID_WIDTH(IDW)) bus ();

   ddr3_rw_arbiter #(.ADDRS(ADDRS), .AXI_ID_WIDTH(IDW), .MAX_RUN(MAX_RUN)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   // model: who holds the port (0 none, 1 read, 2 write), sequences served in this turn,
   // whether reads were served last, and whether a chain is in progress
   int   m_gnt;
   int   m_run;
   bit   m_last_rd;
   bit   m_lock;
   int   checks;
   int   failures;
   logic e_req, e_rdwr, e_seq, e_racc, e_wacc;
   logic [3:0]  e_id;
   logic [31:0] e_addr;
   cmd_t rq[$];
   cmd_t wq[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drv(input logic rf, input logic rs, input logic [31:0] ra,
                      input logic ws, input logic ww, input logic [31:0] wa, input logic acc);
      bus.rd_fetch_i   = rf;
      bus.rd_rseq_i    = rs;
      bus.rd_reqid_i   = 4'h3;
      bus.rd_addr_i    = ra;
      bus.wr_store_i   = ws;
      bus.wr_wseq_i    = ww;
      bus.wr_reqid_i   = 4'h5;
      bus.wr_addr_i    = wa;
      bus.mem_accept_i = acc;
   endtask

   task automatic cmp_cycle();
      #1;
      e_req  = (m_gnt == 1) ? bus.rd_fetch_i : (m_gnt == 2) ? bus.wr_store_i : 1'b0;
      e_rdwr = (m_gnt != 2);
      e_seq  = (m_gnt == 1) ? bus.rd_rseq_i  : (m_gnt == 2) ? bus.wr_wseq_i  : 1'b0;
      e_id   = (m_gnt == 1) ? bus.rd_reqid_i : (m_gnt == 2) ? bus.wr_reqid_i : 4'h0;
      e_addr = (m_gnt == 1) ? bus.rd_addr_i  : (m_gnt == 2) ? bus.wr_addr_i  : 32'h0;
      e_racc = (m_gnt == 1) && bus.mem_accept_i && bus.rd_fetch_i;
      e_wacc = (m_gnt == 2) && bus.mem_accept_i && bus.wr_store_i;
      chk("mem_req",   bus.mem_req_o,   e_req);
      chk("mem_rdwr",  bus.mem_rdwr_o,  e_rdwr);
      chk("mem_seq",   bus.mem_seq_o,   e_seq);
      chk("mem_reqid", bus.mem_reqid_o, e_id);
      chk("mem_addr",  bus.mem_addr_o,  e_addr);
      chk("rd_accept", bus.rd_accept_o, e_racc);
      chk("wr_accept", bus.wr_accept_o, e_wacc);
      chk("one_accept", bus.rd_accept_o & bus.wr_accept_o, 1'b0);
   endtask

   // advance the model by one clock from the currently driven inputs, then wait a full cycle
   task automatic tick();
      int  ng, nr, old_run;
      bit  nl, nk, cv, ov, cs, sw;
      ng = m_gnt; nr = m_run; nl = m_last_rd; nk = m_lock;
      if (reset) begin
         ng = 0; nr = 0; nl = 1'b0; nk = 1'b0;
      end else if (m_gnt == 0) begin
         if (bus.rd_fetch_i && bus.wr_store_i) ng = m_last_rd ? 2 : 1;
         else if (bus.rd_fetch_i)              ng = 1;
         else if (bus.wr_store_i)              ng = 2;
      end else begin
         cv = (m_gnt == 1) ? bus.rd_fetch_i : bus.wr_store_i;
         ov = (m_gnt == 1) ? bus.wr_store_i : bus.rd_fetch_i;
         cs = (m_gnt == 1) ? bus.rd_rseq_i  : bus.wr_wseq_i;
         if (cv && bus.mem_accept_i) begin
            if (cs) begin
               nk = 1'b1;
            end else begin
               nk      = 1'b0;
               old_run = m_run;
               nr      = (m_run + 1 > MAX_RUN) ? MAX_RUN : m_run + 1;
`ifdef ARB_BATCH_EN
               sw = (old_run + 1 >= MAX_RUN);
`else
               sw = 1'b1;
`endif
               if (ov && sw) begin
                  nl = (m_gnt == 1); ng = 3 - m_gnt; nr = 0;
               end
            end
         end else if (!m_lock && !cv) begin
            if (ov) begin
               nl = (m_gnt == 1); ng = 3 - m_gnt; nr = 0;
            end else begin
               ng = 0; nr = 0;
            end
         end
      end
      @(posedge clock);
      m_gnt = ng; m_run = nr; m_last_rd = nl; m_lock = nk;
      @(negedge clock);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      cmp_cycle();
      tick();
      reset = 1'b0;
   endtask

   task automatic gen_cmds(input bit is_rd, input int n);
      cmd_t c;
      int   len;
      for (int k = 0; k < n; k++) begin
         len = $urandom_range(1, 4);
         for (int j = 0; j < len; j++) begin
            c.addr = $urandom;
            c.id   = 4'($urandom_range(0, 15));
            c.seq  = (j < len - 1);
            if (is_rd) rq.push_back(c);
            else       wq.push_back(c);
         end
      end
   endtask

   initial begin
      int budget;
      checks = 0; failures = 0;
      m_gnt = 0; m_run = 0; m_last_rd = 1'b0; m_lock = 1'b0;
      reset = 1'b1;
      drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      @(posedge clock);
      @(negedge clock);

      // reset values
      do_reset();
      cmp_cycle();
      chk("rst_req", bus.mem_req_o, 1'b0);
      chk("rst_rdwr", bus.mem_rdwr_o, 1'b1);
      chk("rst_addr", bus.mem_addr_o, 32'h0);
      tick();

      // reads only: first request visible one cycle after fetch
      do_reset();
      drv(1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 32'h0, 1'b1);
      cmp_cycle(); chk("t1_lat", bus.mem_req_o, 1'b0); tick();
      cmp_cycle(); chk("t1_req", bus.mem_req_o, 1'b1); chk("t1_a0", bus.mem_addr_o, 32'h100);
      chk("t1_acc", bus.rd_accept_o, 1'b1); tick();
      drv(1'b1, 1'b0, 32'h140, 1'b0, 1'b0, 32'h0, 1'b1);
      cmp_cycle(); chk("t1_a1", bus.mem_addr_o, 32'h140); tick();
      drv(1'b1, 1'b0, 32'h180, 1'b0, 1'b0, 32'h0, 1'b1);
      cmp_cycle(); chk("t1_a2", bus.mem_addr_o, 32'h180); chk("t1_rdwr", bus.mem_rdwr_o, 1'b1); tick();
      drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
      cmp_cycle(); tick();

      // tie after reset goes to read; chain of three reads is not split by a pending write
      do_reset();
      drv(1'b1, 1'b1, 32'h200, 1'b1, 1'b0, 32'h800, 1'b1);
      cmp_cycle(); chk("t2_idle", bus.mem_req_o, 1'b0); tick();
      cmp_cycle(); chk("t2_r0", bus.rd_accept_o, 1'b1); chk("t2_w0", bus.wr_accept_o, 1'b0); tick();
      drv(1'b1, 1'b1, 32'h240, 1'b1, 1'b0, 32'h800, 1'b1);
      cmp_cycle(); chk("t2_r1", bus.rd_accept_o, 1'b1); chk("t2_w1", bus.wr_accept_o, 1'b0); tick();
      drv(1'b1, 1'b0, 32'h280, 1'b1, 1'b0, 32'h800, 1'b1);
      cmp_cycle(); chk("t2_r2", bus.rd_accept_o, 1'b1); chk("t2_w2", bus.wr_accept_o, 1'b0); tick();
      drv(1'b1, 1'b0, 32'h2c0, 1'b1, 1'b0, 32'h800, 1'b1);
      cmp_cycle();
`ifdef ARB_BATCH_EN
      chk("t3_batch", bus.mem_rdwr_o, 1'b1);
`else
      chk("t3_alt_rdwr", bus.mem_rdwr_o, 1'b0);
      chk("t3_alt_addr", bus.mem_addr_o, 32'h800);
`endif
      tick();

      // stall inside a locked read chain
      do_reset();
      drv(1'b1, 1'b1, 32'h300, 1'b1, 1'b0, 32'h900, 1'b1);
      cmp_cycle(); tick();
      cmp_cycle(); chk("t4_lock", bus.rd_accept_o, 1'b1); tick();
      for (int i = 0; i < 5; i++) begin
         drv(1'b0, 1'b1, 32'h340, 1'b1, 1'b0, 32'h900, 1'b1);
         cmp_cycle();
         chk("t4_req", bus.mem_req_o, 1'b0);
         chk("t4_rdwr", bus.mem_rdwr_o, 1'b1);
         chk("t4_wacc", bus.wr_accept_o, 1'b0);
         tick();
      end
      drv(1'b1, 1'b0, 32'h340, 1'b1, 1'b0, 32'h900, 1'b1);
      cmp_cycle(); chk("t4_end", bus.rd_accept_o, 1'b1); tick();

      // backpressure with both sides pending
      do_reset();
      drv(1'b1, 1'b0, 32'h400, 1'b1, 1'b0, 32'ha00, 1'b0);
      cmp_cycle(); tick();
      for (int i = 0; i < 10; i++) begin
         cmp_cycle();
         chk("t5_req", bus.mem_req_o, 1'b1);
         chk("t5_addr", bus.mem_addr_o, 32'h400);
         chk("t5_racc", bus.rd_accept_o, 1'b0);
         chk("t5_wacc", bus.wr_accept_o, 1'b0);
         tick();
      end
      drv(1'b1, 1'b0, 32'h400, 1'b1, 1'b0, 32'ha00, 1'b1);
      cmp_cycle(); chk("t5_go", bus.rd_accept_o, 1'b1); tick();

      // reset in the middle of a chain, then a lone write
      do_reset();
      drv(1'b1, 1'b1, 32'h500, 1'b0, 1'b0, 32'h0, 1'b1);
      cmp_cycle(); tick();
      cmp_cycle(); chk("t6_lock", bus.rd_accept_o, 1'b1); tick();
      reset = 1'b1;
      drv(1'b1, 1'b1, 32'h540, 1'b0, 1'b0, 32'h0, 1'b1);
      cmp_cycle(); tick();
      reset = 1'b0;
      drv(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'hb00, 1'b1);
      cmp_cycle();
      chk("t6_req", bus.mem_req_o, 1'b0); chk("t6_rdwr", bus.mem_rdwr_o, 1'b1);
      chk("t6_addr", bus.mem_addr_o, 32'h0); chk("t6_seq", bus.mem_seq_o, 1'b0);
      tick();
      cmp_cycle();
      chk("t6_wreq", bus.mem_req_o, 1'b1); chk("t6_wrdwr", bus.mem_rdwr_o, 1'b0);
      chk("t6_wacc", bus.wr_accept_o, 1'b1);
      tick();

      // randomized traffic: every command must leave exactly once and in order
      do_reset();
      gen_cmds(1'b1, 25);
      gen_cmds(1'b0, 25);
      budget = 0;
      while ((rq.size() != 0 || wq.size() != 0) && budget < 6000) begin
         if (rq.size() != 0) begin
            bus.rd_fetch_i = ($urandom_range(0, 9) < 8);
            bus.rd_addr_i  = rq[0].addr;
            bus.rd_reqid_i = rq[0].id;
            bus.rd_rseq_i  = rq[0].seq;
         end else begin
            bus.rd_fetch_i = 1'b0;
         end
         if (wq.size() != 0) begin
            bus.wr_store_i = ($urandom_range(0, 9) < 8);
            bus.wr_addr_i  = wq[0].addr;
            bus.wr_reqid_i = wq[0].id;
            bus.wr_wseq_i  = wq[0].seq;
         end else begin
            bus.wr_store_i = 1'b0;
         end
         bus.mem_accept_i = ($urandom_range(0, 3) != 0);
         cmp_cycle();
         if (e_racc) begin
            chk("sb_rd_addr", bus.mem_addr_o, rq[0].addr);
            chk("sb_rd_id", bus.mem_reqid_o, rq[0].id);
            void'(rq.pop_front());
         end
         if (e_wacc) begin
            chk("sb_wr_addr", bus.mem_addr_o, wq[0].addr);
            chk("sb_wr_id", bus.mem_reqid_o, wq[0].id);
            void'(wq.pop_front());
         end
         tick();
         budget++;
      end
      chk("drain_rd", rq.size(), 0);
      chk("drain_wr", wq.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
